ram_seq_ctrl: RTL and testbench
===============================

Name: ram_seq_ctrl

Overview:
Command sequencer sitting directly upstream of the 64x8 single-port RAM; owns that RAM's In/Address/ChipSelect/Write pins. Accepts one command per handshake (fill-write or burst-read of 1..64 bytes), issues one RAM access per clk, and returns read bytes on a registered strobe. Lets the bus/test logic reach the RAM without tracking its one-cycle read latency.

Parameters:
ADDR_W, 6, RAM address width; depth = 2**ADDR_W
DATA_W, 8, RAM data width

Ports:
clk  in  1  single clock; all state changes on posedge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted on the clk edge where cmd_valid & cmd_ready
cmd_write  in  1  1 = fill-write, 0 = burst-read
cmd_incr  in  1  write only: 1 = data increments by 1 per byte (mod 256), 0 = constant data
cmd_addr  in  ADDR_W  start address
cmd_len  in  ADDR_W  byte count minus 1 (0 -> 1 byte, 63 -> 64 bytes)
cmd_data  in  DATA_W  first write byte
ram_in  out  DATA_W  to RAM In
ram_addr  out  ADDR_W  to RAM Address
ram_cs  out  1  to RAM ChipSelect
ram_we  out  1  to RAM Write
ram_out  in  DATA_W  from RAM Out (valid the cycle after an access with cs=1)
rd_valid  out  1  one-cycle strobe per returned byte; no backpressure
rd_data  out  DATA_W  returned byte, registered
rd_addr  out  ADDR_W  address that rd_data came from
busy  out  1  ~cmd_ready
checksum  out  DATA_W  see Optional Feature

Behaviour:
- Reset (async, any time including mid-burst): state IDLE, cmd_ready=1, ram_cs=ram_we=0, ram_in=ram_addr=0, rd_valid=0, rd_data=rd_addr=0, checksum=0; in-flight reads discarded, no rd_valid for them after reset.
- All RAM-side outputs are registered; ram_cs=0 and ram_we=0 in every cycle with no access.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: on accept, latch addr, remaining count = cmd_len, data, incr; go WRITE if cmd_write, else READ. cmd fields ignored outside the accept edge.
- WRITE: each cycle drives ram_cs=1, ram_we=1, ram_addr=cur, ram_in=cur_data; addr += 1 mod 64; data += cmd_incr. After len+1 cycles -> IDLE. The first access is in the cycle after the accept edge; cmd_ready is high again in the cycle after the last write cycle.
- READ: each cycle drives ram_cs=1, ram_we=0, ram_addr=cur; addr += 1 mod 64. A 2-deep valid/address pipe tracks issued reads. After len+1 issues -> DRAIN.
- Read latency: issue cycle N -> RAM captures at end of N -> ram_out valid in N+1 -> rd_data/rd_addr/rd_valid registered, high in N+2.
- DRAIN: no RAM access; wait until the pipe is empty, then IDLE. cmd_ready rises in the same cycle rd_valid shows the last byte.
- Address wrap: 63 -> 0 silently; len=63 from any start covers every location exactly once.
- Read-after-write needs no hazard logic: commands are serialized and a write completes before IDLE.

Optional Feature:
RAM_SEQ_CHECKSUM_EN
- Defined: checksum register cleared on accept of each read command; XORed with rd_data on every rd_valid. Holds the final value until the next read accept or reset.
- Undefined: checksum tied to 0; no register is inferred.

Decomposition:
- Package ram_seq_pkg: ADDR_W/DATA_W defaults, FSM state enum (IDLE, WRITE, READ, DRAIN), op encoding constants.
- One sub-module: ram_seq_rdpipe (2-stage valid/address delay line plus output registers, checksum logic inside). The FSM and address/data counters stay in the top.

Test Plan:
- Single write then read: write addr=5 data=0xA7 len=0; read addr=5 len=0 -> one rd_valid, 2 cycles after the issue cycle, rd_data=0xA7, rd_addr=5.
- Incrementing fill with wrap: write addr=62 len=3 data=0x10 incr=1; read addr=62 len=3 -> rd_data 0x10,0x11,0x12,0x13 at rd_addr 62,63,0,1 on 4 consecutive cycles.
- Full-depth: constant fill 0x5A len=63 from addr 17; read len=63 from addr 0 -> 64 strobes, all 0x5A, rd_addr 0..63; cmd_ready low throughout, high on the last-strobe cycle.
- Handshake: hold cmd_valid high with changing fields while busy -> only the IDLE-edge command executes; each command gets exactly len+1 RAM accesses (count ram_cs cycles).
- Reset mid-read: assert rst during the 3rd cycle of a len=7 read -> outputs zero immediately (async), no further rd_valid, cmd_ready=1 after release, next command runs normally.
- With RAM_SEQ_CHECKSUM_EN: fill 0x01,0x02,0x04,0x08 (incr=0, four single writes), read len=3 -> checksum=0x0F after the last strobe; without the macro, checksum stays 0.

Source files
------------

// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: shared definitions for the RAM command sequencer.
//   - default address/data widths of the 64x8 single-port RAM
//   - sequencer FSM state encoding
//   - command opcode encoding for cmd_write
package ram_seq_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/ram_seq_rdpipe.sv
// ram_seq_rdpipe: tracks reads issued to the RAM and registers the returned
// bytes so the consumer never sees the RAM's one-cycle read latency.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   iss_vld_i         a read access is on the RAM pins this cycle
//   iss_addr_i        address of that access
//   ram_out_i         RAM data out (valid the cycle after the access)
//   csum_clr_i        a read command is being accepted on this edge
//   rd_valid_o        one-cycle strobe per returned byte
//   rd_data_o         returned byte
//   rd_addr_o         address the byte came from
//   checksum_o        XOR of all bytes of the current/last read command
//
// Build option: RAM_SEQ_CHECKSUM_EN enables the checksum register; without it
// checksum_o is constant zero.
module ram_seq_rdpipe #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              iss_vld_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic [DATA_W-1:0] ram_out_i,
  input  logic              csum_clr_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] checksum_o
);

  logic              vld_p0_q;
  logic [ADDR_W-1:0] addr_p0_q;
  logic              vld_p1_q;
  logic [DATA_W-1:0] data_p1_q;
  logic [ADDR_W-1:0] addr_p1_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0_q  <= 1'b0;
      addr_p0_q <= '0;
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      addr_p1_q <= '0;
    end else begin
      // stage p0: RAM is capturing the access; ram_out valid next cycle
      vld_p0_q  <= iss_vld_i;
      addr_p0_q <= iss_addr_i;
      // stage p1: register the returned byte alongside its address
      vld_p1_q  <= vld_p0_q;
      if (vld_p0_q) begin
        data_p1_q <= ram_out_i;
        addr_p1_q <= addr_p0_q;
      end
    end
  end

  assign rd_valid_o = vld_p1_q;
  assign rd_data_o  = data_p1_q;
  assign rd_addr_o  = addr_p1_q;

`ifdef RAM_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  // Accumulate at the same edge that loads rd_data, so the final value is
  // visible together with the last strobe. Accepts only happen in IDLE, when
  // no byte of a new command can be in flight, so clear never loses a byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum_q <= '0;
    end else if (csum_clr_i) begin
      csum_q <= '0;
    end else if (vld_p0_q) begin
      csum_q <= csum_q ^ ram_out_i;
    end
  end

  assign checksum_o = csum_q;
`else
  logic unused_csum_clr;
  assign unused_csum_clr = csum_clr_i;
  assign checksum_o      = '0;
`endif

endmodule

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: command sequencer in front of a single-port RAM. Accepts one
// fill-write or burst-read command per handshake and issues one registered RAM
// access per clock; read bytes come back on a registered strobe.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (ready only in IDLE)
//   cmd_write, cmd_incr           opcode; incrementing write data
//   cmd_addr, cmd_len, cmd_data   start address, byte count - 1, first byte
//   ram_in, ram_addr, ram_cs, ram_we   registered RAM pin drivers
//   ram_out                       RAM read data (one cycle after access)
//   rd_valid, rd_data, rd_addr    returned read byte
//   busy                          ~cmd_ready
//   checksum                      XOR of read bytes (RAM_SEQ_CHECKSUM_EN)
//
// Build option: RAM_SEQ_CHECKSUM_EN (see ram_seq_rdpipe).
module ram_seq_ctrl
  import ram_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_incr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_out,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic [DATA_W-1:0] checksum
);

  state_e            state_q, state_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_in_q, ram_in_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  // next access address/data and accesses remaining after the current one
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              incr_q, incr_d;
  logic              accept;
  logic              rd_accept;
  logic              rd_issue;

  assign accept    = (state_q == IDLE) && cmd_valid;
  assign rd_accept = accept && (cmd_write == OP_READ);
  assign rd_issue  = ram_cs_q && !ram_we_q;

  always_comb begin
    state_d    = state_q;
    ram_cs_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_in_d   = ram_in_q;
    ram_addr_d = ram_addr_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    incr_d     = incr_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          // The first access is loaded straight into the pin registers so
          // it appears in the cycle after the accept edge.
          ram_cs_d   = 1'b1;
          ram_we_d   = (cmd_write == OP_WRITE);
          ram_addr_d = cmd_addr;
          if (cmd_write == OP_WRITE) ram_in_d = cmd_data;
          addr_d     = cmd_addr + ADDR_W'(1);
          cnt_d      = cmd_len;
          incr_d     = cmd_incr;
          data_d     = cmd_data + DATA_W'(cmd_incr);
          state_d    = (cmd_write == OP_WRITE) ? WRITE : READ;
        end
      end
      WRITE, READ: begin
        if (cnt_q == '0) begin
          // the access on the pins now is the last one
          state_d = (state_q == WRITE) ? IDLE : DRAIN;
        end else begin
          ram_cs_d   = 1'b1;
          ram_we_d   = (state_q == WRITE);
          ram_addr_d = addr_q;
          if (state_q == WRITE) ram_in_d = data_q;
          addr_d     = addr_q + ADDR_W'(1);
          data_d     = data_q + DATA_W'(incr_q);
          cnt_d      = cnt_q - ADDR_W'(1);
        end
      end
      DRAIN: begin
        // No read is on the pins, so the only byte left sits in the first
        // pipe stage and reaches rd_valid on this edge together with IDLE.
        if (!rd_issue) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_in_q   <= '0;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_in_q   <= ram_in_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  // Counters are always loaded on accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    cnt_q  <= cnt_d;
    data_q <= data_d;
    incr_q <= incr_d;
  end

  ram_seq_rdpipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rdpipe (
    .clk_i      (clk),
    .rst_i      (rst),
    .iss_vld_i  (rd_issue),
    .iss_addr_i (ram_addr_q),
    .ram_out_i  (ram_out),
    .csum_clr_i (rd_accept),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .rd_addr_o  (rd_addr),
    .checksum_o (checksum)
  );

  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_in    = ram_in_q;
  assign ram_addr  = ram_addr_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Testbench for ram_seq_ctrl with a behavioural 64x8 single-port RAM.
// Command table drives the main traffic; a scoreboard queue of expected read
// bytes (from a shadow memory) is checked on every rd_valid.
module tb_ram_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic       cmd_incr = 1'b0;
  logic [5:0] cmd_addr = '0;
  logic [5:0] cmd_len = '0;
  logic [7:0] cmd_data = '0;
  logic [7:0] ram_in;
  logic [5:0] ram_addr;
  logic       ram_cs;
  logic       ram_we;
  logic [7:0] ram_out = '0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [5:0] rd_addr;
  logic       busy;
  logic [7:0] checksum;

  ram_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_incr  (cmd_incr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .ram_in    (ram_in),
    .ram_addr  (ram_addr),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_out   (ram_out),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // behavioural single-port RAM: read data valid the cycle after the access
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_in;
      else        ram_out <= mem[ram_addr];
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [5:0] addr;
    logic       last;
  } exp_t;

  typedef struct {
    bit         w;
    bit         inc;
    logic [5:0] addr;
    logic [5:0] len;
    logic [7:0] data;
    bit         garbage;
    int         exp_acc;
  } vec_t;

  exp_t       exp_q[$];
  int         iss_q[$];
  logic [7:0] shadow [64];
  logic [7:0] exp_csum = '0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  vec_t       tbl [13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every rd_valid must match the oldest expected byte, arrive
  // two cycles after its issue cycle, and coincide with cmd_ready only on the
  // last byte of a command
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ram_cs && !ram_we) iss_q.push_back(cyc);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", int'(rd_data), int'(e.data));
          chk("rd_addr", int'(rd_addr), int'(e.addr));
          chk("ready_on_strobe", int'(cmd_ready), int'(e.last));
        end
        if (iss_q.size() == 0) chk("strobe_without_issue", 1, 0);
        else chk("rd_latency", cyc - iss_q.pop_front(), 2);
      end
    end
  end

  task automatic scramble();
    cmd_write = 1'($urandom_range(0, 1));
    cmd_incr  = 1'($urandom_range(0, 1));
    cmd_addr  = 6'($urandom);
    cmd_len   = 6'($urandom);
    cmd_data  = 8'($urandom);
  endtask

  task automatic run_cmd(input vec_t v);
    int         acc;
    bit         done;
    logic [7:0] cs;
    logic [5:0] ai;
    exp_t       e;
    @(negedge clk);
    chk("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = v.w; cmd_incr = v.inc;
    cmd_addr = v.addr; cmd_len = v.len; cmd_data = v.data;
    cs = '0;
    for (int i = 0; i <= int'(v.len); i++) begin
      ai = v.addr + 6'(i);
      if (v.w) begin
        shadow[ai] = v.data + (v.inc ? 8'(i) : 8'h00);
      end else begin
        e.data = shadow[ai]; e.addr = ai; e.last = (i == int'(v.len));
        exp_q.push_back(e);
        cs = cs ^ shadow[ai];
      end
    end
    @(negedge clk);
    if (v.garbage) scramble();
    else cmd_valid = 1'b0;
    chk("first_acc_cs", int'(ram_cs), 1);
    chk("first_acc_we", int'(ram_we), int'(v.w));
    chk("first_acc_addr", int'(ram_addr), int'(v.addr));
    if (v.w) chk("first_acc_in", int'(ram_in), int'(v.data));
    chk("busy_during_cmd", int'(busy), 1);
    acc = 1;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (ram_cs) acc++;
      if (cmd_ready) begin
        done = 1'b1;
        cmd_valid = 1'b0;
      end else if (v.garbage) begin
        scramble();
      end
    end
    chk("cmd_done_in_time", int'(done), 1);
    chk("access_count", acc, v.exp_acc);
    if (!v.w) begin
`ifdef RAM_SEQ_CHECKSUM_EN
      exp_csum = cs;
`else
      exp_csum = 8'h00;
`endif
    end
    chk("checksum", int'(checksum), int'(exp_csum));
  endtask

  initial begin
    //          w  inc addr   len    data   garb acc
    tbl[0]  = '{1, 0, 6'd5,  6'd0,  8'hA7, 0, 1};
    tbl[1]  = '{0, 0, 6'd5,  6'd0,  8'h00, 0, 1};
    tbl[2]  = '{1, 1, 6'd62, 6'd3,  8'h10, 0, 4};
    tbl[3]  = '{0, 0, 6'd62, 6'd3,  8'h00, 0, 4};
    tbl[4]  = '{1, 0, 6'd17, 6'd63, 8'h5A, 0, 64};
    tbl[5]  = '{0, 0, 6'd0,  6'd63, 8'h00, 0, 64};
    tbl[6]  = '{1, 1, 6'd10, 6'd5,  8'hFE, 1, 6};
    tbl[7]  = '{0, 0, 6'd8,  6'd9,  8'h00, 1, 10};
    tbl[8]  = '{1, 0, 6'd20, 6'd0,  8'h01, 0, 1};
    tbl[9]  = '{1, 0, 6'd21, 6'd0,  8'h02, 0, 1};
    tbl[10] = '{1, 0, 6'd22, 6'd0,  8'h04, 0, 1};
    tbl[11] = '{1, 0, 6'd23, 6'd0,  8'h08, 0, 1};
    tbl[12] = '{0, 0, 6'd20, 6'd3,  8'h00, 0, 4};

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ram_cs", int'(ram_cs), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_in", int'(ram_in), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_checksum", int'(checksum), 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_cmd(tbl[i]);
`ifdef RAM_SEQ_CHECKSUM_EN
    chk("checksum_0F", int'(checksum), 8'h0F);
`else
    chk("checksum_off", int'(checksum), 8'h00);
`endif

    // reset in the 3rd issue cycle of an 8-byte read
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd40; cmd_len = 6'd7;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.data = shadow[6'd40 + 6'(i)]; e.addr = 6'd40 + 6'(i); e.last = (i == 7);
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ram_cs", int'(ram_cs), 0);
    chk("midrst_ram_addr", int'(ram_addr), 0);
    chk("midrst_rd_valid", int'(rd_valid), 0);
    chk("midrst_rd_data", int'(rd_data), 0);
    chk("midrst_rd_addr", int'(rd_addr), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    chk("midrst_checksum", int'(checksum), 0);
    exp_q.delete();
    iss_q.delete();
    exp_csum = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);
    run_cmd(tbl[1]);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
